// File: rtl/wbsp2axlite.sv
// Wishbone pipelined slave to AXI4-Lite master bridge: one outstanding
// transaction, busy timeout that errors the WB side and drains the AXI side.
module wbsp2axlite #(
   parameter int C_AXI_DATA_WIDTH = 32,
   parameter int C_AXI_ADDR_WIDTH = 28,
   parameter int TIMEOUT_CYCLES   = 16,
   localparam int DW  = C_AXI_DATA_WIDTH,
   localparam int LSB = $clog2(C_AXI_DATA_WIDTH / 8),
   localparam int AW  = C_AXI_ADDR_WIDTH - LSB
) (
   input  logic                        i_clk,
   input  logic                        i_axi_reset_n,
   input  logic                        i_wb_cyc,
   input  logic                        i_wb_stb,
   input  logic                        i_wb_we,
   input  logic [AW-1:0]               i_wb_addr,
   input  logic [DW-1:0]               i_wb_data,
   input  logic [DW/8-1:0]             i_wb_sel,
   output logic                        o_wb_stall,
   output logic                        o_wb_ack,
   output logic                        o_wb_err,
   output logic [DW-1:0]               o_wb_data,
   output logic                        o_axi_awvalid,
   input  logic                        i_axi_awready,
   output logic [C_AXI_ADDR_WIDTH-1:0] o_axi_awaddr,
   output logic                        o_axi_wvalid,
   input  logic                        i_axi_wready,
   output logic [DW-1:0]               o_axi_wdata,
   output logic [DW/8-1:0]             o_axi_wstrb,
   input  logic                        i_axi_bvalid,
   output logic                        o_axi_bready,
   input  logic [1:0]                  i_axi_bresp,
   output logic                        o_axi_arvalid,
   input  logic                        i_axi_arready,
   output logic [C_AXI_ADDR_WIDTH-1:0] o_axi_araddr,
   input  logic                        i_axi_rvalid,
   output logic                        o_axi_rready,
   input  logic [DW-1:0]               i_axi_rdata,
   input  logic [1:0]                  i_axi_rresp
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      WRITE = 2'd1,
      READ  = 2'd2,
      DRAIN = 2'd3
   } state_t;

   state_t            state_r, state_s;
   logic              we_r;
   logic [AW-1:0]     addr_r;
   logic [DW-1:0]     wdata_r;
   logic [DW/8-1:0]   wstrb_r;
   logic [DW-1:0]     rdata_r;
   logic              awvalid_r, wvalid_r, arvalid_r, bready_r, rready_r;
   logic              stall_r, ack_r, err_r, abort_r;
   logic [7:0]        busy_cnt_r;

   logic accept_s, aw_ok_s, w_ok_s, ar_ok_s, b_fire_s, r_fire_s;
   logic timeout_s, live_s, resp_err_s, ack_s, err_s;
   logic unused_s;

   // A channel counts as done once its valid has dropped or handshakes this cycle.
   assign accept_s   = (state_r == IDLE) && i_wb_cyc && i_wb_stb;
   assign aw_ok_s    = !awvalid_r || i_axi_awready;
   assign w_ok_s     = !wvalid_r || i_axi_wready;
   assign ar_ok_s    = !arvalid_r || i_axi_arready;
   assign b_fire_s   = bready_r && i_axi_bvalid && aw_ok_s && w_ok_s;
   assign r_fire_s   = rready_r && i_axi_rvalid && ar_ok_s;
   assign timeout_s  = (busy_cnt_r == 8'(TIMEOUT_CYCLES - 1));
   assign live_s     = i_wb_cyc && !abort_r;
   assign resp_err_s = we_r ? i_axi_bresp[1] : i_axi_rresp[1];
   assign unused_s   = ^{i_axi_bresp[0], i_axi_rresp[0]};

   // State register.
   always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
      if (!i_axi_reset_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next state and WB response decisions; a completing handshake beats the timeout.
   always_comb begin
      state_s = state_r;
      ack_s   = 1'b0;
      err_s   = 1'b0;
      case (state_r)
         IDLE: begin
            if (accept_s) begin
               if (i_wb_we) begin
                  state_s = WRITE;
               end else begin
                  state_s = READ;
               end
            end else begin
               state_s = IDLE;
            end
         end
         WRITE, READ: begin
            if (b_fire_s || r_fire_s) begin
               state_s = IDLE;
               ack_s   = live_s && !resp_err_s;
               err_s   = live_s && resp_err_s;
            end else if (timeout_s) begin
               state_s = DRAIN;
               err_s   = live_s;
            end else begin
               state_s = state_r;
            end
         end
         DRAIN: begin
            if (b_fire_s || r_fire_s) begin
               state_s = IDLE;
            end else begin
               state_s = DRAIN;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Request capture, AXI channel handshakes, busy counter and WB outputs.
   always_ff @(posedge i_clk or negedge i_axi_reset_n) begin
      if (!i_axi_reset_n) begin
         we_r       <= 1'b0;
         addr_r     <= '0;
         wdata_r    <= '0;
         wstrb_r    <= '0;
         rdata_r    <= '0;
         awvalid_r  <= 1'b0;
         wvalid_r   <= 1'b0;
         arvalid_r  <= 1'b0;
         bready_r   <= 1'b0;
         rready_r   <= 1'b0;
         stall_r    <= 1'b0;
         ack_r      <= 1'b0;
         err_r      <= 1'b0;
         abort_r    <= 1'b0;
         busy_cnt_r <= 8'd0;
      end else begin
         if (accept_s) begin
            we_r    <= i_wb_we;
            addr_r  <= i_wb_addr;
            wdata_r <= i_wb_data;
            wstrb_r <= i_wb_sel;
         end

         if (accept_s) begin
            awvalid_r <= i_wb_we;
         end else if (i_axi_awready) begin
            awvalid_r <= 1'b0;
         end

         if (accept_s) begin
            wvalid_r <= i_wb_we;
         end else if (i_axi_wready) begin
            wvalid_r <= 1'b0;
         end

         if (accept_s) begin
            arvalid_r <= !i_wb_we;
         end else if (i_axi_arready) begin
            arvalid_r <= 1'b0;
         end

         bready_r <= (state_s == WRITE) || ((state_s == DRAIN) && we_r);
         rready_r <= (state_s == READ)  || ((state_s == DRAIN) && !we_r);
         stall_r  <= (state_s != IDLE);
         ack_r    <= ack_s;
         err_r    <= err_s;

         // Once the master abandons the cycle, nothing is reported for this request.
         if (accept_s) begin
            abort_r <= 1'b0;
         end else if ((state_r != IDLE) && !i_wb_cyc) begin
            abort_r <= 1'b1;
         end

         if (((state_r == WRITE) || (state_r == READ)) && (state_s == state_r)) begin
            busy_cnt_r <= busy_cnt_r + 8'd1;
         end else begin
            busy_cnt_r <= 8'd0;
         end

         if ((state_r == READ) && r_fire_s) begin
            rdata_r <= i_axi_rdata;
         end
      end
   end

   assign o_wb_stall    = stall_r;
   assign o_wb_ack      = ack_r;
   assign o_wb_err      = err_r;
   assign o_wb_data     = rdata_r;
   assign o_axi_awvalid = awvalid_r;
   assign o_axi_awaddr  = C_AXI_ADDR_WIDTH'(addr_r) << LSB;
   assign o_axi_wvalid  = wvalid_r;
   assign o_axi_wdata   = wdata_r;
   assign o_axi_wstrb   = wstrb_r;
   assign o_axi_bready  = bready_r;
   assign o_axi_arvalid = arvalid_r;
   assign o_axi_araddr  = C_AXI_ADDR_WIDTH'(addr_r) << LSB;
   assign o_axi_rready  = rready_r;

endmodule
